// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes and FSM states.
package universal_shift_reg_pkg;

  localparam logic [2:0] MODE_SHL = 3'd0;
  localparam logic [2:0] MODE_SHR = 3'd1;
  localparam logic [2:0] MODE_ROL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ASR = 3'd4;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Codes 5-7 run as HOLD: they step the counter but move no data.
  function automatic logic is_shift_mode(logic [2:0] mode);
    return mode <= MODE_ASR;
  endfunction

endpackage

// File: rtl/universal_shift_reg_step.sv
// Combinational single-step shifter: one 1-bit shift/rotate of value per mode.
module universal_shift_reg_step
  import universal_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  // Select next value and departing bit; reserved modes pass the value through.
  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (mode)
      MODE_SHL: begin
        next_value = {value[WIDTH-2:0], fill};
        out_bit    = value[WIDTH-1];
      end
      MODE_SHR: begin
        next_value = {fill, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      MODE_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      MODE_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      MODE_ASR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-mode shift register with busy/done handshake, one bit per cycle.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  input  logic             pause,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_value;
  logic             step_out;

  universal_shift_reg_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value      (data_q),
    .mode       (mode_q),
    .fill       (serial_in),
    .next_value (step_value),
    .out_bit    (step_out)
  );

  // Next-state logic: load/start decode in IDLE, one step per unpaused edge in SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    so_d    = so_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          data_d = data_in;
        end else if (start) begin
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode;
            cnt_d   = amount;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (!pause) begin
          data_d = step_value;
          // HOLD modes shift nothing out, so serial_out keeps its last value.
          if (is_shift_mode(mode_q)) begin
            so_d = step_out;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation without done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= MODE_SHL;
      data_q  <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs; busy and done are mutually exclusive by construction.
  always_comb begin
    data_out   = data_q;
    serial_out = so_q;
    busy       = (state_q == StShift);
    done       = done_q;
  end

endmodule
